// File: rtl/coin_dispenser.sv
// coin_dispenser: greedy coin payout engine with per-tube stock, hopper handshake and jam timeout
module coin_dispenser #(
    parameter logic [3:0] INIT_STOCK  = 4'd15,
    parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       coin_ack,
    input  logic       refill,
    output logic [4:0] coin_out,
    output logic       coin_valid,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic       jam,
    output logic [7:0] remainder,
    output logic [3:0] five,
    output logic [3:0] ten,
    output logic [3:0] twenty,
    output logic [3:0] fifty,
    output logic [3:0] hundred
);
    typedef enum logic [1:0] {IDLE, SELECT, WAIT_ACK, FINISH} state_t;

    state_t      state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [4:0]  coin_out_q, coin_out_d;
    logic        coin_valid_q, coin_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        short_q, short_d;
    logic        jam_q, jam_d;
    logic [7:0]  remainder_q, remainder_d;
    logic [3:0]  stock_q [5];
    logic [3:0]  stock_d [5];
    logic [3:0]  cnt_q [5];
    logic [3:0]  cnt_d [5];
    logic        found;
    logic [2:0]  pick;

    // tube index 0..4 maps to 5, 10, 20, 50, 100 rupees
    function automatic logic [7:0] denom(input logic [2:0] i);
        return i == 3'd0 ? 8'd5 : i == 3'd1 ? 8'd10 : i == 3'd2 ? 8'd20 : i == 3'd3 ? 8'd50 : 8'd100;
    endfunction

    // next-state logic: largest payable coin is chosen each SELECT, stock and counts update on ack
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        coin_out_d   = coin_out_q;
        coin_valid_d = coin_valid_q;
        done_d       = 1'b0;
        short_d      = short_q;
        jam_d        = jam_q;
        remainder_d  = remainder_q;
        stock_d      = stock_q;
        cnt_d        = cnt_q;
        found        = 1'b0;
        pick         = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (denom(3'(i)) <= rem_q && stock_q[i] != 4'd0) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d       = amount;
                    jam_d       = 1'b0;
                    short_d     = 1'b0;
                    remainder_d = 8'd0;
                    for (int i = 0; i < 5; i++) cnt_d[i] = 4'd0;
                    state_d     = SELECT;
                end else if (refill) begin
                    for (int i = 0; i < 5; i++) stock_d[i] = INIT_STOCK;
                end
            end
            SELECT: begin
                if (found) begin
                    idx_d        = pick;
                    coin_out_d   = 5'b1 << pick;
                    coin_valid_d = 1'b1;
                    tmo_d        = 8'd0;
                    state_d      = WAIT_ACK;
                end else begin
                    done_d      = 1'b1;
                    remainder_d = rem_q;
                    short_d     = rem_q != 8'd0;
                    state_d     = FINISH;
                end
            end
            WAIT_ACK: begin
                if (coin_ack) begin
                    rem_d          = rem_q - denom(idx_q);
                    stock_d[idx_q] = stock_q[idx_q] - 4'd1;
                    cnt_d[idx_q]   = cnt_q[idx_q] + 4'd1;
                    coin_valid_d   = 1'b0;
                    coin_out_d     = 5'd0;
                    state_d        = SELECT;
                end else if (tmo_q == ACK_TIMEOUT - 8'd1) begin
                    jam_d        = 1'b1;
                    coin_valid_d = 1'b0;
                    coin_out_d   = 5'd0;
                    done_d       = 1'b1;
                    remainder_d  = rem_q;
                    short_d      = rem_q != 8'd0;
                    state_d      = FINISH;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // state and registered outputs; reset abandons any in-flight coin and restocks every tube
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rem_q        <= 8'd0;
            idx_q        <= 3'd0;
            tmo_q        <= 8'd0;
            coin_out_q   <= 5'd0;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            jam_q        <= 1'b0;
            remainder_q  <= 8'd0;
            for (int i = 0; i < 5; i++) begin
                stock_q[i] <= INIT_STOCK;
                cnt_q[i]   <= 4'd0;
            end
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            coin_out_q   <= coin_out_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            short_q      <= short_d;
            jam_q        <= jam_d;
            remainder_q  <= remainder_d;
            stock_q      <= stock_d;
            cnt_q        <= cnt_d;
        end
    end

    assign coin_out   = coin_out_q;
    assign coin_valid = coin_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign short      = short_q;
    assign jam        = jam_q;
    assign remainder  = remainder_q;
    assign five       = cnt_q[0];
    assign ten        = cnt_q[1];
    assign twenty     = cnt_q[2];
    assign fifty      = cnt_q[3];
    assign hundred    = cnt_q[4];
endmodule

// File: tb/tb_coin_dispenser.sv
// tb_coin_dispenser: randomized payouts checked against a greedy change-making model
module tb_coin_dispenser;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] amount = 8'd0;
    logic       coin_ack = 1'b0;
    logic       refill = 1'b0;
    logic [4:0] coin_out;
    logic       coin_valid, busy, done, short, jam;
    logic [7:0] remainder;
    logic [3:0] five, ten, twenty, fifty, hundred;
    int checks = 0;
    int failures = 0;
    int m_stock [5];
    int den [5] = '{5, 10, 20, 50, 100};

    coin_dispenser #(.INIT_STOCK(4'd15), .ACK_TIMEOUT(8'd8)) dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount), .coin_ack(coin_ack),
        .refill(refill), .coin_out(coin_out), .coin_valid(coin_valid), .busy(busy),
        .done(done), .short(short), .jam(jam), .remainder(remainder), .five(five),
        .ten(ten), .twenty(twenty), .fifty(fifty), .hundred(hundred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic restock();
        for (int k = 0; k < 5; k++) m_stock[k] = 15;
    endtask

    task automatic do_refill();
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
        restock();
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_valid"}, 32'(coin_valid), 0);
        chk({tag, "_coin"}, 32'(coin_out), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_counts"}, 32'({five, ten, twenty, fifty, hundred}), 0);
        chk({tag, "_rem"}, 32'(remainder), 0);
        chk({tag, "_flags"}, 32'({short, jam}), 0);
    endtask

    task automatic pay(input logic [7:0] amt, input int lo, input int hi, input bit hold_low, input bit with_refill);
        logic [4:0] exp_q [$];
        logic [4:0] got_q [$];
        logic [4:0] first;
        int st [5];
        int ec [5];
        int rem, t, vcyc, last_vcyc, waited, delay;
        bit in_coin, seen_done, jammed;
        st = m_stock;
        rem = int'(amt);
        jammed = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            ec[k] = 0;
            while (den[k] <= rem && st[k] > 0) begin
                exp_q.push_back(5'(1 << k));
                rem -= den[k];
                st[k]--;
                ec[k]++;
            end
        end
        if (hold_low && exp_q.size() > 0) begin
            jammed = 1'b1;
            first = exp_q[0];
            exp_q.delete();
            exp_q.push_back(first);
            for (int k = 0; k < 5; k++) ec[k] = 0;
            rem = int'(amt);
        end else begin
            m_stock = st;
        end
        start = 1'b1;
        amount = amt;
        refill = with_refill;
        @(posedge clk); #1;
        start = 1'b0;
        refill = 1'b0;
        amount = 8'($urandom);
        chk("busy_t0", 32'(busy), 1);
        in_coin = 1'b0;
        seen_done = 1'b0;
        t = 0;
        vcyc = 0;
        last_vcyc = 0;
        waited = 0;
        delay = 0;
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (coin_valid) begin
                    if (!in_coin) begin
                        in_coin = 1'b1;
                        waited = 0;
                        vcyc = 0;
                        delay = int'($urandom_range(hi, lo));
                        got_q.push_back(coin_out);
                    end else begin
                        chk("coin_stable", 32'(coin_out), 32'(got_q[$]));
                    end
                    vcyc++;
                    coin_ack = !hold_low && waited >= delay;
                    waited++;
                    start = 1'($urandom_range(0, 1));
                    refill = 1'($urandom_range(0, 1));
                end else begin
                    if (in_coin) last_vcyc = vcyc;
                    in_coin = 1'b0;
                    coin_ack = 1'($urandom_range(0, 1));
                    start = 1'b0;
                    refill = 1'b0;
                end
                @(posedge clk); #1;
                t++;
            end
        end
        if (in_coin) last_vcyc = vcyc;
        coin_ack = 1'b0;
        start = 1'b0;
        refill = 1'b0;
        chk("done_seen", 32'(seen_done), 1);
        chk("remainder", 32'(remainder), 32'(rem));
        chk("short", 32'(short), 32'(rem != 0));
        chk("jam", 32'(jam), 32'(jammed));
        chk("five", 32'(five), 32'(ec[0]));
        chk("ten", 32'(ten), 32'(ec[1]));
        chk("twenty", 32'(twenty), 32'(ec[2]));
        chk("fifty", 32'(fifty), 32'(ec[3]));
        chk("hundred", 32'(hundred), 32'(ec[4]));
        chk("busy_finish", 32'(busy), 1);
        chk("n_coins", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("coin_seq", 32'(got_q[i]), 32'(exp_q[i]));
        if (lo == 0 && hi == 0 && !hold_low)
            chk("done_cycle", 32'(t), 32'(2 * exp_q.size() + 1));
        if (jammed)
            chk("jam_valid_cycles", 32'(last_vcyc), 8);
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("rem_hold", 32'(remainder), 32'(rem));
    endtask

    initial begin
        restock();
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        reset = 1'b0;
        pay(8'd185, 0, 0, 1'b0, 1'b0);
        pay(8'd7, 0, 0, 1'b0, 1'b0);
        pay(8'd0, 0, 0, 1'b0, 1'b0);
        pay(8'd10, 0, 0, 1'b1, 1'b0);
        do_refill();
        pay(8'd10, 0, 0, 1'b0, 1'b0);
        pay(8'd150, 3, 3, 1'b0, 1'b0);
        begin
            int n;
            start = 1'b1;
            amount = 8'd150;
            @(posedge clk); #1;
            start = 1'b0;
            n = 0;
            while (!coin_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("mid_first_coin", 32'(coin_out), 32'(5'b10000));
            coin_ack = 1'b1;
            @(posedge clk); #1;
            coin_ack = 1'b0;
            chk("mid_hundred", 32'(hundred), 1);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            restock();
            check_idle_zero("midreset");
        end
        pay(8'd100, 0, 0, 1'b0, 1'b0);
        pay(8'd200, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) pay(8'd255, 0, 0, 1'b0, 1'b0);
        pay(8'd5, 0, 0, 1'b0, 1'b0);
        pay(8'd200, 0, 0, 1'b0, 1'b0);
        do_refill();
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 7) == 0) do_refill();
            pay(8'($urandom), 0, int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
